regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: req0 (ALU writeback) and req1 (memory/load writeback).
- Each requester uses a valid/ready handshake.
- Arbitration is round-robin. The winning write is registered for one cycle and then driven to the register file as address, data and a 16-bit one-hot write-enable vector.
- Supports a downstream stall and optional protection of R15 (PC).

---
 rtl/regfile_write_arbiter_pkg.sv | 23 ++
 rtl/regfile_write_arbiter_if.sv | 33 +++
 rtl/regfile_write_arbiter_decoder.sv | 11 +
 rtl/regfile_write_arbiter.sv | 92 +++++++++
 tb/tb_regfile_write_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and the output-stage state for the register-file write arbiter.
package regfile_write_arbiter_pkg;

    localparam int           REG_ADDR_W = 4;
    localparam int           NUM_REGS   = 16;
    localparam logic [3:0]   PC_REG     = 4'd15;
    localparam logic         REQ_ALU    = 1'b0;
    localparam logic         REQ_MEM    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_STALL
    } wr_state_e;

    // The output stage carries no state encoding of its own: valid flop plus stall says it all.
    function automatic wr_state_e wr_state(input logic valid, input logic stall);
        if (!valid)     return ST_IDLE;
        else if (stall) return ST_STALL;
        else            return ST_WRITE;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshakes plus the registered register-file write port.
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic                  req0_valid;
    logic [REG_ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0]     req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [REG_ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0]     req1_data;
    logic                  req1_ready;
    logic                  wr_stall;
    logic                  wr_valid;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [NUM_REGS-1:0]   wr_en;
    logic [NUM_REGS-1:0]   busy;
    logic                  drop;

    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, wr_stall,
        input  req0_ready, req1_ready, wr_valid, wr_addr, wr_data, wr_en, busy, drop
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, wr_stall,
        output req0_ready, req1_ready, wr_valid, wr_addr, wr_data, wr_en, busy, drop
    );

endinterface

// File: rtl/regfile_write_arbiter_decoder.sv
// 4-to-16 one-hot decoder.
module decoder4to16
    import regfile_write_arbiter_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] a_i,
    output logic [NUM_REGS-1:0]   y_o
);

    assign y_o = NUM_REGS'(1) << a_i;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU and load writeback.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter bit PROTECT_R15 = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    wr_state_e             state;
    logic                  can_accept;
    logic                  contested;
    logic                  gnt0;
    logic                  gnt1;
    logic                  any_gnt;
    logic                  sel_is_pc;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic [NUM_REGS-1:0]   dec;

    logic                  rr_q, rr_d;
    logic                  wr_valid_q, wr_valid_d;
    logic                  drop_q, drop_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;

    assign state      = wr_state(wr_valid_q, bus.wr_stall);
    assign can_accept = !reset && (state != ST_STALL);
    assign contested  = bus.req0_valid && bus.req1_valid;
    assign gnt0       = can_accept && bus.req0_valid && (!contested || rr_q == REQ_ALU);
    assign gnt1       = can_accept && bus.req1_valid && (!contested || rr_q == REQ_MEM);
    assign any_gnt    = gnt0 || gnt1;
    assign sel_addr   = gnt1 ? bus.req1_addr : bus.req0_addr;
    assign sel_data   = gnt1 ? bus.req1_data : bus.req0_data;
    assign sel_is_pc  = PROTECT_R15 && (sel_addr == PC_REG);

    always_comb begin
        rr_d       = rr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        drop_d     = 1'b0;
        if (any_gnt) begin
            if (contested) rr_d = gnt0 ? REQ_MEM : REQ_ALU;
            // A protected PC write still handshakes; it just never reaches the port.
            if (sel_is_pc) begin
                wr_valid_d = 1'b0;
                drop_d     = 1'b1;
            end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = sel_addr;
                wr_data_d  = sel_data;
            end
        end else if (state == ST_WRITE) begin
            wr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q       <= REQ_ALU;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            drop_q     <= drop_d;
        end
    end

    decoder4to16 u_dec (
        .a_i (wr_addr_q),
        .y_o (dec)
    );

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_en      = dec & {NUM_REGS{wr_valid_q}};
    assign bus.busy       = dec & {NUM_REGS{wr_valid_q}};
    assign bus.drop       = drop_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of the write arbiter against a transaction-level model.
module tb_regfile_write_arbiter;

    localparam int DW      = 32;
    localparam bit PROTECT = 1'b1;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    // model of what the write port presents, and which requester wins a tie next
    logic          m_valid;
    logic [3:0]    m_addr;
    logic [DW-1:0] m_data;
    logic          m_drop;
    int            m_fav;
    logic          e_r0, e_r1;

    regfile_write_arbiter_if #(.DATA_W(DW)) bus ();

    regfile_write_arbiter #(.DATA_W(DW), .PROTECT_R15(PROTECT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_en();
        return m_valid ? (16'h1 << m_addr) : 16'h0;
    endfunction

    task automatic drive(input logic r, input logic v0, input logic [3:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [3:0] a1, input logic [DW-1:0] d1, input logic st);
        int  win;
        logic acc;
        reset = r;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        bus.wr_stall = st;
        #1;
        acc  = !r && !(m_valid && st);
        win  = (v0 && v1) ? m_fav : v0 ? 0 : v1 ? 1 : -1;
        e_r0 = acc && (win == 0);
        e_r1 = acc && (win == 1);
    endtask

    task automatic tick();
        int            w;
        logic [3:0]    a;
        logic [DW-1:0] d;
        if (reset) begin
            m_valid = 0; m_addr = 0; m_data = 0; m_drop = 0; m_fav = 0;
        end else begin
            m_drop = 0;
            if (e_r0 || e_r1) begin
                w = e_r1 ? 1 : 0;
                a = e_r1 ? bus.req1_addr : bus.req0_addr;
                d = e_r1 ? bus.req1_data : bus.req0_data;
                if (bus.req0_valid && bus.req1_valid) m_fav = 1 - w;
                if (PROTECT && a == 4'd15) begin
                    m_valid = 0; m_drop = 1;
                end else begin
                    m_valid = 1; m_addr = a; m_data = d;
                end
            end else if (!bus.wr_stall) begin
                m_valid = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        drive(1, 1, 4'd2, 32'h11, 1, 4'd3, 32'h22, 0);
        tick();
        drive(1, 1, 4'd2, 32'h11, 1, 4'd3, 32'h22, 0);
        checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready); end
        checks++; if (bus.wr_valid !== 1'b0 || bus.wr_en !== 16'h0 || bus.busy !== 16'h0 || bus.drop !== 1'b0) begin errors++;
            $display("FAIL reset_out: got v=%b en=%h busy=%h drop=%b want 0", bus.wr_valid, bus.wr_en, bus.busy, bus.drop); end
        checks++; if (bus.wr_addr !== 4'h0 || bus.wr_data !== 32'h0) begin errors++;
            $display("FAIL reset_regs: got addr=%h data=%h want 0", bus.wr_addr, bus.wr_data); end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        drive(0, 1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 0);
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++;
            $display("FAIL single_ready: got %b%b want 10", bus.req0_ready, bus.req1_ready); end
        tick();
        idle();
        checks++; if (bus.wr_valid !== 1'b1 || bus.wr_en !== 16'h0008 || bus.wr_data !== 32'hDEADBEEF) begin errors++;
            $display("FAIL single_write: got v=%b en=%h data=%h want 1 0008 deadbeef", bus.wr_valid, bus.wr_en, bus.wr_data); end
        tick();
        idle();
        checks++; if (bus.wr_en !== 16'h0 || bus.wr_valid !== 1'b0) begin errors++;
            $display("FAIL single_clear: got v=%b en=%h want 0 0000", bus.wr_valid, bus.wr_en); end
    endtask

    task automatic test_contention();
        logic [15:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 4'd1, DW'(i), 1, 4'd2, DW'(i + 100), 0);
            checks++; if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin errors++;
                $display("FAIL rr_grant[%0d]: got %b%b want %b%b", i, bus.req0_ready, bus.req1_ready, i % 2 == 0, i % 2 == 1); end
            want = (i == 0) ? 16'h0 : ((i - 1) % 2 == 0) ? 16'h0002 : 16'h0004;
            checks++; if (bus.wr_en !== want) begin errors++;
                $display("FAIL rr_en[%0d]: got %h want %h", i, bus.wr_en, want); end
            tick();
        end
        idle();
        checks++; if (bus.wr_en !== 16'h0004 || bus.wr_data !== 32'd103) begin errors++;
            $display("FAIL rr_last: got en=%h data=%h want 0004 103", bus.wr_en, bus.wr_data); end
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        drive(0, 0, 0, 0, 1, 4'd7, 32'h77, 0);
        checks++; if (bus.req1_ready !== 1'b1) begin errors++;
            $display("FAIL stall_accept: got %b want 1", bus.req1_ready); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'd4, 32'h44, 0, 0, 0, 1);
            checks++; if (bus.wr_en !== 16'h0080 || bus.req0_ready !== 1'b0 || bus.wr_data !== 32'h77) begin errors++;
                $display("FAIL stall_hold[%0d]: got en=%h rdy=%b data=%h want 0080 0 77", i, bus.wr_en, bus.req0_ready, bus.wr_data); end
            tick();
        end
        drive(0, 1, 4'd4, 32'h44, 0, 0, 0, 0);
        checks++; if (bus.wr_en !== 16'h0080 || bus.req0_ready !== 1'b1) begin errors++;
            $display("FAIL stall_release: got en=%h rdy=%b want 0080 1", bus.wr_en, bus.req0_ready); end
        tick();
        idle();
        checks++; if (bus.wr_en !== 16'h0010 || bus.wr_data !== 32'h44) begin errors++;
            $display("FAIL stall_next: got en=%h data=%h want 0010 44", bus.wr_en, bus.wr_data); end
        tick();
        // stall with an empty output stage must not block acceptance
        drive(0, 1, 4'd6, 32'h66, 0, 0, 0, 1);
        checks++; if (bus.req0_ready !== 1'b1) begin errors++;
            $display("FAIL stall_idle: got %b want 1", bus.req0_ready); end
        tick();
        idle();
        checks++; if (bus.wr_en !== 16'h0040) begin errors++;
            $display("FAIL stall_idle_wr: got %h want 0040", bus.wr_en); end
        tick();
    endtask

    task automatic test_r15();
        do_reset();
        drive(0, 1, 4'd15, 32'h1234, 0, 0, 0, 0);
        checks++; if (bus.req0_ready !== 1'b1) begin errors++;
            $display("FAIL r15_ready: got %b want 1", bus.req0_ready); end
        tick();
        idle();
        checks++; if (bus.drop !== 1'b1 || bus.wr_valid !== 1'b0 || bus.wr_en !== 16'h0) begin errors++;
            $display("FAIL r15_drop: got drop=%b v=%b en=%h want 1 0 0000", bus.drop, bus.wr_valid, bus.wr_en); end
        tick();
        idle();
        checks++; if (bus.drop !== 1'b0) begin errors++;
            $display("FAIL r15_pulse: got %b want 0", bus.drop); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 1, 4'd1, 32'h1, 1, 4'd2, 32'h2, 0);
        tick();
        drive(0, 1, 4'd5, 32'h55, 0, 0, 0, 0);
        checks++; if (bus.req0_ready !== 1'b1) begin errors++;
            $display("FAIL mid_accept: got %b want 1", bus.req0_ready); end
        tick();
        drive(1, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 0);
        checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.wr_en !== 16'h0020) begin errors++;
            $display("FAIL mid_in_reset: got rdy=%b%b en=%h want 00 0020", bus.req0_ready, bus.req1_ready, bus.wr_en); end
        tick();
        drive(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 0);
        checks++; if (bus.wr_valid !== 1'b0) begin errors++;
            $display("FAIL mid_discard: got %b want 0", bus.wr_valid); end
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++;
            $display("FAIL mid_rr: got %b%b want 10", bus.req0_ready, bus.req1_ready); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_collision();
        do_reset();
        drive(0, 1, 4'd9, 32'hAAAA, 1, 4'd9, 32'hBBBB, 0);
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++;
            $display("FAIL col_first: got %b%b want 10", bus.req0_ready, bus.req1_ready); end
        tick();
        drive(0, 0, 0, 0, 1, 4'd9, 32'hBBBB, 0);
        checks++; if (bus.req1_ready !== 1'b1 || bus.wr_en !== 16'h0200 || bus.wr_data !== 32'hAAAA) begin errors++;
            $display("FAIL col_a: got rdy=%b en=%h data=%h want 1 0200 aaaa", bus.req1_ready, bus.wr_en, bus.wr_data); end
        tick();
        idle();
        checks++; if (bus.wr_en !== 16'h0200 || bus.wr_data !== 32'hBBBB) begin errors++;
            $display("FAIL col_b: got en=%h data=%h want 0200 bbbb", bus.wr_en, bus.wr_data); end
        tick();
    endtask

    task automatic test_random();
        logic p0, p1, st, r;
        logic [3:0] a0, a1;
        logic [DW-1:0] d0, d1;
        p0 = 0; p1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if (!p0 && $urandom_range(9) < 6) begin p0 = 1; a0 = 4'($urandom); d0 = $urandom; end
            if (!p1 && $urandom_range(9) < 6) begin p1 = 1; a1 = 4'($urandom); d1 = $urandom; end
            st = ($urandom_range(9) < 3);
            r  = ($urandom_range(49) == 0);
            drive(r, p0, a0, d0, p1, a1, d1, st);
            checks++; if (bus.req0_ready !== e_r0 || bus.req1_ready !== e_r1) begin errors++;
                $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", i, bus.req0_ready, bus.req1_ready, e_r0, e_r1); end
            checks++; if (bus.wr_valid !== m_valid || bus.wr_en !== exp_en() || bus.busy !== exp_en() || bus.drop !== m_drop) begin errors++;
                $display("FAIL rnd_out[%0d]: got v=%b en=%h busy=%h drop=%b want %b %h %b", i, bus.wr_valid, bus.wr_en, bus.busy, bus.drop, m_valid, exp_en(), m_drop); end
            if (m_valid) begin
                checks++; if (bus.wr_addr !== m_addr || bus.wr_data !== m_data) begin errors++;
                    $display("FAIL rnd_data[%0d]: got %h/%h want %h/%h", i, bus.wr_addr, bus.wr_data, m_addr, m_data); end
            end
            checks++; if ($countones(bus.wr_en) != (bus.wr_valid ? 1 : 0)) begin errors++;
                $display("FAIL rnd_onehot[%0d]: got en=%h v=%b want one-hot iff valid", i, bus.wr_en, bus.wr_valid); end
            if (e_r0) p0 = 0;
            if (e_r1) p1 = 0;
            tick();
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        m_valid = 0; m_addr = 0; m_data = 0; m_drop = 0; m_fav = 0; e_r0 = 0; e_r1 = 0;
        reset = 1;
        bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_data = 0;
        bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_data = 0;
        bus.wr_stall = 0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_r15();
        test_reset_mid();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
